// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;
  // MMIO window base, and register offsets as word index within the window
  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
  localparam logic [1:0]  OFF_TXDATA = 2'd0;  // 0x8000_0000
  localparam logic [1:0]  OFF_STATUS = 2'd1;  // 0x8000_0004
  localparam logic [1:0]  OFF_CYCLE  = 2'd2;  // 0x8000_0008
  localparam logic [1:0]  OFF_CMP    = 2'd3;  // 0x8000_000C

  // STATUS bit positions
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_CNT   = 2;  // 3-bit saturating count at [4:2]
  localparam int ST_OVF   = 5;
  localparam int ST_TICK  = 8;

  typedef enum logic [1:0] {RGN_RAM, RGN_MMIO, RGN_NONE} region_e;
endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the TX valid/ready stream; head reads 0 while empty.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          pop_ready,
  output logic                          valid,
  output logic [7:0]                    head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          pop, push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign valid   = !empty;
  assign pop     = valid && pop_ready;
  // a full FIFO still takes a byte when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign ovf     = push && full && !pop;
  assign head    = empty ? 8'h00 : mem[rd_ptr];
  assign count   = cnt;

  // pointers and occupancy; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop);
    end
  end

  // storage is not reset; empty masking hides stale bytes
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus an MMIO window (TX FIFO, cycle counter, compare).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADD_SIZE   = 32,
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [ADD_SIZE-1:0] i_d_add,
  input  logic [WIDTH-1:0]    i_w_data,
  output logic [WIDTH-1:0]    o_r_data,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_tick
);
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADD_SIZE-1:0] BASE = ADD_SIZE'(MMIO_BASE);

  logic [ADD_SIZE-3:0] word;
  logic [1:0]          off;
  region_e             rgn;
  logic                unused_lsb;

  assign word       = i_d_add[ADD_SIZE-1:2];
  assign off        = i_d_add[3:2];
  assign unused_lsb = &{1'b0, i_d_add[1:0]};

  // region decode on the word address
  always_comb begin
    rgn = RGN_NONE;
    if (word < (ADD_SIZE-2)'(RAM_WORDS))                rgn = RGN_RAM;
    else if (i_d_add[ADD_SIZE-1:4] == BASE[ADD_SIZE-1:4]) rgn = RGN_MMIO;
  end

  logic wr_ram, wr_mmio, wr_tx, wr_st, wr_cyc, wr_cmp;
  assign wr_ram  = i_we && (rgn == RGN_RAM);
  assign wr_mmio = i_we && (rgn == RGN_MMIO);
  assign wr_tx   = wr_mmio && (off == OFF_TXDATA);
  assign wr_st   = wr_mmio && (off == OFF_STATUS);
  assign wr_cyc  = wr_mmio && (off == OFF_CYCLE);
  assign wr_cmp  = wr_mmio && (off == OFF_CMP);

  logic [WIDTH-1:0] ram [RAM_WORDS];

  // RAM write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (wr_ram) ram[word[RAW-1:0]] <= i_w_data;
  end

  logic          f_full, f_empty, f_ovf;
  logic [CW-1:0] f_cnt;

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (wr_tx),
    .push_data (i_w_data[7:0]),
    .pop_ready (i_tx_ready),
    .valid     (o_tx_valid),
    .head      (o_tx_data),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_cnt),
    .ovf       (f_ovf)
  );

  logic [WIDTH-1:0] cycle, cmp;
  logic             tick, ovf;

  // counter, compare and sticky flags; set beats a same-cycle clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycle <= '0;
      cmp   <= '0;
      tick  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      cycle <= wr_cyc ? i_w_data : cycle + WIDTH'(1);
      if (wr_cmp) cmp <= i_w_data;
      if (cycle == cmp)                   tick <= 1'b1;
      else if (wr_st && i_w_data[ST_TICK]) tick <= 1'b0;
      if (f_ovf)                          ovf <= 1'b1;
      else if (wr_st && i_w_data[ST_OVF])  ovf <= 1'b0;
    end
  end

  assign o_tick = tick;

  logic [2:0] cnt_sat;

  // combinational read mux
  always_comb begin
    cnt_sat  = (int'(f_cnt) > 7) ? 3'd7 : 3'(f_cnt);
    o_r_data = '0;
    case (rgn)
      RGN_RAM:  o_r_data = ram[word[RAW-1:0]];
      RGN_MMIO: begin
        case (off)
          OFF_STATUS: begin
            o_r_data[ST_FULL]       = f_full;
            o_r_data[ST_EMPTY]      = f_empty;
            o_r_data[ST_CNT +: 3]   = cnt_sat;
            o_r_data[ST_OVF]        = ovf;
            o_r_data[ST_TICK]       = tick;
          end
          OFF_CYCLE: o_r_data = cycle;
          OFF_CMP:   o_r_data = cmp;
          default:   o_r_data = '0;
        endcase
      end
      default: o_r_data = '0;
    endcase
  end
endmodule
